// File: rtl/branch_resolve_ctrl_pkg.sv
// branch_resolve_ctrl_pkg: shared FSM states, BHT counter encodings and helpers
package branch_resolve_ctrl_pkg;

    typedef enum logic {IDLE, FLUSH} state_t;

    localparam logic [1:0] SNT       = 2'd0;
    localparam logic [1:0] WNT       = 2'd1;
    localparam logic [1:0] WT        = 2'd2;
    localparam logic [1:0] ST        = 2'd3;
    localparam logic [1:0] BHT_RESET = WNT;

    localparam int INSTR_BYTES = 4;

    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        return taken ? ((cnt == ST) ? ST : cnt + 2'd1) : ((cnt == SNT) ? SNT : cnt - 2'd1);
    endfunction

endpackage

// File: rtl/branch_resolve_ctrl_bht.sv
// bht_table: 2-bit saturating branch history table, async read, sync update
module bht_table
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    logic [1:0] tbl [2**IDX_W];

    assign rd_taken = tbl[rd_idx][1];

    // counters start weakly not-taken and train toward each resolved outcome
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**IDX_W; i++) tbl[i] <= BHT_RESET;
        end else if (wr_en) begin
            tbl[wr_idx] <= sat_update(tbl[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: IF branch prediction, EX resolution, redirect and flush control
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int IDX_W        = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  if_pc,
    input  logic             if_is_branch,
    input  logic [XLEN-1:0]  if_target,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             ex_taken,
    input  logic             ex_pred_taken,
    input  logic             stall,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             busy,
    output logic [CNT_W-1:0] mispredict_count
);

    state_t     state, state_d;
    logic [2:0] cnt, cnt_d;
    logic       rd_taken;
    logic       res, mis;

    // wrong-path branches seen while flushing never resolve
    assign res = ex_valid & ex_branch & ~stall & (state == IDLE);
    assign mis = res & (ex_taken != ex_pred_taken);

    assign pred_taken  = if_is_branch & rd_taken;
    assign pred_target = pred_taken ? if_target : if_pc + XLEN'(INSTR_BYTES);

    bht_table #(.IDX_W(IDX_W)) u_bht (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (if_pc[IDX_W+1:2]),
        .rd_taken (rd_taken),
        .wr_en    (res),
        .wr_idx   (ex_pc[IDX_W+1:2]),
        .wr_taken (ex_taken)
    );

    // flush FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // flush length counts only non-stalled cycles
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        if (state == IDLE) begin
            state_d = mis ? FLUSH : IDLE;
            cnt_d   = mis ? 3'(FLUSH_CYCLES) : cnt;
        end else if (!stall) begin
            state_d = (cnt == 3'd1) ? IDLE : FLUSH;
            cnt_d   = cnt - 3'd1;
        end
        flush_ifid = (state == FLUSH);
        flush_idex = (state == FLUSH);
        busy       = (state == FLUSH);
    end

    // redirect raised after a mispredict, held until fetch consumes it in a non-stalled cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else if (mis) begin
            redirect_valid <= 1'b1;
            redirect_pc    <= ex_taken ? ex_target : ex_pc + XLEN'(INSTR_BYTES);
        end else if (!stall) begin
            redirect_valid <= 1'b0;
        end
    end

    // saturating mispredict counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mispredict_count <= '0;
        else if (mis && mispredict_count != '1) mispredict_count <= mispredict_count + 1'b1;
    end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl: directed vector table plus reset-during-flush sequence
module tb_branch_resolve_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] if_pc = '0, if_target = '0, ex_pc = '0, ex_target = '0;
    logic        if_is_branch = 1'b0, ex_valid = 1'b0, ex_branch = 1'b0;
    logic        ex_taken = 1'b0, ex_pred_taken = 1'b0, stall = 1'b0;
    logic        pred_taken, redirect_valid, flush_ifid, flush_idex, busy;
    logic [31:0] pred_target, redirect_pc;
    logic [15:0] mispredict_count;

    int total = 0;
    int bad   = 0;

    branch_resolve_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_pc            (if_pc),
        .if_is_branch     (if_is_branch),
        .if_target        (if_target),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .ex_valid         (ex_valid),
        .ex_branch        (ex_branch),
        .ex_pc            (ex_pc),
        .ex_target        (ex_target),
        .ex_taken         (ex_taken),
        .ex_pred_taken    (ex_pred_taken),
        .stall            (stall),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .flush_ifid       (flush_ifid),
        .flush_idex       (flush_idex),
        .busy             (busy),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ipc; logic ibr; logic [31:0] itg;
        logic ev; logic eb; logic [31:0] epc; logic [31:0] etg; logic et; logic ep; logic st;
        logic pt; logic [31:0] ptg; logic rv; logic [31:0] rpc; logic fl; logic [15:0] mc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic [31:0] ipc, input logic ibr, input logic [31:0] itg,
        input logic ev, input logic eb, input logic [31:0] epc, input logic [31:0] etg,
        input logic et, input logic ep, input logic st,
        input logic pt, input logic [31:0] ptg, input logic rv, input logic [31:0] rpc,
        input logic fl, input logic [15:0] mc);
        vec_t v;
        v.ipc = ipc; v.ibr = ibr; v.itg = itg; v.ev = ev; v.eb = eb; v.epc = epc; v.etg = etg;
        v.et = et; v.ep = ep; v.st = st; v.pt = pt; v.ptg = ptg; v.rv = rv; v.rpc = rpc;
        v.fl = fl; v.mc = mc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        // fetch/ex inputs                                               | pred, pred_tgt, rv, rpc, flush, count
        vecs.push_back(mk(32'h40,1,32'h80, 0,0,32'h0,32'h0,0,0,0,             0,32'h44,0,32'h0,0,0));  // reset state
        vecs.push_back(mk(32'h40,1,32'h80, 1,1,32'h40,32'h80,1,0,0,           0,32'h44,0,32'h0,0,0));  // mispredict, read-before-write
        vecs.push_back(mk(32'h40,1,32'h80, 1,1,32'h40,32'h80,0,1,0,           1,32'h80,1,32'h80,1,1)); // flush 1, wrong-path ex
        vecs.push_back(mk(32'h40,1,32'h80, 0,0,32'h0,32'h0,0,0,0,             1,32'h80,0,32'h0,1,1));  // flush 2, bht untouched
        vecs.push_back(mk(32'h40,1,32'h80, 1,1,32'h40,32'h80,1,1,0,           1,32'h80,0,32'h0,0,1));  // correct taken, 2->3
        vecs.push_back(mk(32'h40,1,32'h80, 1,1,32'h40,32'h80,1,1,0,           1,32'h80,0,32'h0,0,1));  // 3 saturates
        vecs.push_back(mk(32'h40,1,32'h80, 1,1,32'h40,32'h80,1,1,0,           1,32'h80,0,32'h0,0,1));  // still 3
        vecs.push_back(mk(32'h40,1,32'h80, 1,1,32'h40,32'h80,0,1,0,           1,32'h80,0,32'h0,0,1));  // not taken mispredict
        vecs.push_back(mk(32'h40,1,32'h80, 0,0,32'h0,32'h0,0,0,1,             1,32'h80,1,32'h44,1,2)); // stall 1
        vecs.push_back(mk(32'h40,1,32'h80, 0,0,32'h0,32'h0,0,0,1,             1,32'h80,1,32'h44,1,2)); // stall 2
        vecs.push_back(mk(32'h40,1,32'h80, 1,1,32'h40,32'h80,0,1,1,           1,32'h80,1,32'h44,1,2)); // stall 3, ex ignored
        vecs.push_back(mk(32'h40,1,32'h80, 0,0,32'h0,32'h0,0,0,0,             1,32'h80,1,32'h44,1,2)); // first non-stalled flush
        vecs.push_back(mk(32'h40,1,32'h80, 0,0,32'h0,32'h0,0,0,0,             1,32'h80,0,32'h0,1,2));  // second non-stalled flush
        vecs.push_back(mk(32'h40,1,32'h80, 1,1,32'hFFFFFFFC,32'h100,0,1,0,    1,32'h80,0,32'h0,0,2));  // wrap mispredict
        vecs.push_back(mk(32'hFFFFFFFC,1,32'h10, 0,0,32'h0,32'h0,0,0,0,       0,32'h0,1,32'h0,1,3));   // redirect wraps to 0
        vecs.push_back(mk(32'h40,1,32'h80, 0,0,32'h0,32'h0,0,0,0,             1,32'h80,0,32'h0,1,3));
        vecs.push_back(mk(32'h40,1,32'h80, 1,1,32'h40,32'h80,0,1,1,           1,32'h80,0,32'h0,0,3));  // stalled resolve in IDLE
        vecs.push_back(mk(32'h40,0,32'h80, 0,0,32'h0,32'h0,0,0,0,             0,32'h44,0,32'h0,0,3));  // ignored; non-branch fetch

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            if_pc = vecs[i].ipc; if_is_branch = vecs[i].ibr; if_target = vecs[i].itg;
            ex_valid = vecs[i].ev; ex_branch = vecs[i].eb; ex_pc = vecs[i].epc; ex_target = vecs[i].etg;
            ex_taken = vecs[i].et; ex_pred_taken = vecs[i].ep; stall = vecs[i].st;
            #1;
            chk($sformatf("v%0d pred_taken", i), 32'(pred_taken), 32'(vecs[i].pt));
            chk($sformatf("v%0d pred_target", i), pred_target, vecs[i].ptg);
            chk($sformatf("v%0d redirect_valid", i), 32'(redirect_valid), 32'(vecs[i].rv));
            if (vecs[i].rv) chk($sformatf("v%0d redirect_pc", i), redirect_pc, vecs[i].rpc);
            chk($sformatf("v%0d flush_ifid", i), 32'(flush_ifid), 32'(vecs[i].fl));
            chk($sformatf("v%0d flush_idex", i), 32'(flush_idex), 32'(vecs[i].fl));
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].fl));
            chk($sformatf("v%0d mispredict_count", i), 32'(mispredict_count), 32'(vecs[i].mc));
        end

        // asynchronous reset during the first flush cycle
        @(negedge clk);
        if_pc = 32'h44; if_is_branch = 1'b1; if_target = 32'h200;
        ex_valid = 1'b1; ex_branch = 1'b1; ex_pc = 32'h44; ex_target = 32'h300;
        ex_taken = 1'b1; ex_pred_taken = 1'b0; stall = 1'b0;
        @(negedge clk);
        ex_valid = 1'b0; ex_branch = 1'b0;
        #1;
        chk("rst pre redirect_valid", 32'(redirect_valid), 32'd1);
        chk("rst pre redirect_pc", redirect_pc, 32'h300);
        chk("rst pre busy", 32'(busy), 32'd1);
        chk("rst pre pred_taken", 32'(pred_taken), 32'd1);
        chk("rst pre count", 32'(mispredict_count), 32'd4);
        #1 rst_n = 1'b0;
        #1;
        chk("rst redirect_valid", 32'(redirect_valid), 32'd0);
        chk("rst flush_ifid", 32'(flush_ifid), 32'd0);
        chk("rst flush_idex", 32'(flush_idex), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst count", 32'(mispredict_count), 32'd0);
        chk("rst bht1 pred", 32'(pred_taken), 32'd0);
        chk("rst bht1 target", pred_target, 32'h48);
        if_pc = 32'h40;
        #1;
        chk("rst bht0 pred", 32'(pred_taken), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post rst busy", 32'(busy), 32'd0);
        chk("post rst redirect_valid", 32'(redirect_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
